// File: rtl/lsu_issue_queue.sv
// lsu_issue_queue: in-order load/store issue queue feeding the LSU.
// Entries sit in program order in a circular buffer. Operands arrive either
// with the dispatch or later through CDB wakeup, and only the head entry may
// issue, so a waiting head blocks every younger memory op.
module lsu_issue_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int PREG_WIDTH = 7,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_flush,
    // dispatch side
    input  logic                    i_disp_valid,
    output logic                    o_disp_ready,
    input  logic                    i_disp_memwrite,
    input  logic [3:0]              i_disp_alu_op,
    input  logic [DATA_WIDTH-1:0]   i_disp_imm,
    input  logic [PREG_WIDTH-1:0]   i_disp_prd,
    input  logic [ROB_WIDTH-1:0]    i_disp_rob_tag,
    input  logic [PREG_WIDTH-1:0]   i_disp_prs1,
    input  logic [PREG_WIDTH-1:0]   i_disp_prs2,
    input  logic                    i_disp_rs1_rdy,
    input  logic                    i_disp_rs2_rdy,
    input  logic [DATA_WIDTH-1:0]   i_disp_rs1_val,
    input  logic [DATA_WIDTH-1:0]   i_disp_rs2_val,
    // result broadcast
    input  logic                    i_cdb_valid,
    input  logic [PREG_WIDTH-1:0]   i_cdb_prd,
    input  logic [DATA_WIDTH-1:0]   i_cdb_data,
    // LSU side
    output logic                    o_issue_valid,
    input  logic                    i_lsu_ready,
    output logic [DATA_WIDTH-1:0]   o_base_addr,
    output logic [DATA_WIDTH-1:0]   o_offset,
    output logic [DATA_WIDTH-1:0]   o_store_data,
    output logic                    o_memwrite,
    output logic [3:0]              o_alu_op,
    output logic [PREG_WIDTH-1:0]   o_prd,
    output logic [ROB_WIDTH-1:0]    o_rob_tag,
    // occupancy
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_empty,
    output logic                    o_full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit above the slot index.
    logic [IDX_W:0]   head_ptr;
    logic [IDX_W:0]   tail_ptr;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             ptr_empty;
    logic             ptr_full;

    // Per-entry control state.
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] rs1_rdy;
    logic [DEPTH-1:0] rs2_rdy;
    logic [DEPTH-1:0] memwrite_q;

    // Per-entry payload.
    logic [3:0]            alu_op_q  [DEPTH];
    logic [DATA_WIDTH-1:0] imm_q     [DEPTH];
    logic [PREG_WIDTH-1:0] prd_q     [DEPTH];
    logic [ROB_WIDTH-1:0]  rob_tag_q [DEPTH];
    logic [PREG_WIDTH-1:0] prs1_q    [DEPTH];
    logic [PREG_WIDTH-1:0] prs2_q    [DEPTH];
    logic [DATA_WIDTH-1:0] rs1_val_q [DEPTH];
    logic [DATA_WIDTH-1:0] rs2_val_q [DEPTH];

    // Handshake and wakeup decode.
    logic                  head_ready;
    logic                  do_enq;
    logic                  do_deq;
    logic                  byp_rs1;
    logic                  byp_rs2;
    logic                  enq_rs1_rdy;
    logic                  enq_rs2_rdy;
    logic [DATA_WIDTH-1:0] enq_rs1_val;
    logic [DATA_WIDTH-1:0] enq_rs2_val;
    logic [DEPTH-1:0]      wake_rs1;
    logic [DEPTH-1:0]      wake_rs2;

    assign head_idx  = head_ptr[IDX_W-1:0];
    assign tail_idx  = tail_ptr[IDX_W-1:0];
    assign ptr_empty = (head_ptr == tail_ptr);
    assign ptr_full  = (head_idx == tail_idx) && (head_ptr[IDX_W] != tail_ptr[IDX_W]);

    assign o_empty      = ptr_empty;
    assign o_full       = ptr_full;
    assign o_count      = tail_ptr - head_ptr;
    // Full means no dispatch this cycle even if the head leaves on the same edge;
    // this keeps the dispatch ready path free of the LSU handshake.
    assign o_disp_ready = !ptr_full;

    // Loads only need the base register; stores also need the data register.
    assign head_ready    = rs1_rdy[head_idx] && (!memwrite_q[head_idx] || rs2_rdy[head_idx]);
    assign o_issue_valid = entry_valid[head_idx] && head_ready && !i_flush;

    assign do_enq = i_disp_valid && !ptr_full && !i_flush;
    assign do_deq = o_issue_valid && i_lsu_ready;

    // A source that is still pending at dispatch can be satisfied by the CDB
    // result broadcast on the very same edge.
    assign byp_rs1     = !i_disp_rs1_rdy && i_cdb_valid && (i_disp_prs1 == i_cdb_prd);
    assign byp_rs2     = !i_disp_rs2_rdy && i_cdb_valid && (i_disp_prs2 == i_cdb_prd);
    assign enq_rs1_rdy = i_disp_rs1_rdy || byp_rs1;
    assign enq_rs2_rdy = i_disp_rs2_rdy || byp_rs2;
    assign enq_rs1_val = byp_rs1 ? i_cdb_data : i_disp_rs1_val;
    assign enq_rs2_val = byp_rs2 ? i_cdb_data : i_disp_rs2_val;

    // Head payload is read straight out of the head slot.
    assign o_base_addr  = rs1_val_q[head_idx];
    assign o_offset     = imm_q[head_idx];
    assign o_store_data = rs2_val_q[head_idx];
    assign o_memwrite   = memwrite_q[head_idx];
    assign o_alu_op     = alu_op_q[head_idx];
    assign o_prd        = prd_q[head_idx];
    assign o_rob_tag    = rob_tag_q[head_idx];

    // Find resident entries whose pending source matches the CDB broadcast.
    always_comb begin
        wake_rs1 = '0;
        wake_rs2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wake_rs1[i] = i_cdb_valid && entry_valid[i] && !rs1_rdy[i] && (prs1_q[i] == i_cdb_prd);
            wake_rs2[i] = i_cdb_valid && entry_valid[i] && !rs2_rdy[i] && (prs2_q[i] == i_cdb_prd);
        end
    end

    // Advance head on transfer and tail on accepted dispatch; flush rewinds both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else if (i_flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else begin
            if (do_enq) tail_ptr <= tail_ptr + PTR_ONE;
            if (do_deq) head_ptr <= head_ptr + PTR_ONE;
        end
    end

    // Track entry occupancy and operand readiness, including wakeups.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_valid <= '0;
            rs1_rdy     <= '0;
            rs2_rdy     <= '0;
        end else if (i_flush) begin
            entry_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_enq && (tail_idx == IDX_W'(i))) begin
                    entry_valid[i] <= 1'b1;
                    rs1_rdy[i]     <= enq_rs1_rdy;
                    rs2_rdy[i]     <= enq_rs2_rdy;
                end else begin
                    if (do_deq && (head_idx == IDX_W'(i))) entry_valid[i] <= 1'b0;
                    if (wake_rs1[i]) rs1_rdy[i] <= 1'b1;
                    if (wake_rs2[i]) rs2_rdy[i] <= 1'b1;
                end
            end
        end
    end

    // Capture operand values at dispatch or from a matching CDB broadcast.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rs1_val_q[i] <= '0;
                rs2_val_q[i] <= '0;
            end
        end else if (!i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_enq && (tail_idx == IDX_W'(i))) begin
                    rs1_val_q[i] <= enq_rs1_val;
                    rs2_val_q[i] <= enq_rs2_val;
                end else begin
                    if (wake_rs1[i]) rs1_val_q[i] <= i_cdb_data;
                    if (wake_rs2[i]) rs2_val_q[i] <= i_cdb_data;
                end
            end
        end
    end

    // Latch the static op fields into the tail slot on dispatch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memwrite_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                alu_op_q[i]  <= '0;
                imm_q[i]     <= '0;
                prd_q[i]     <= '0;
                rob_tag_q[i] <= '0;
                prs1_q[i]    <= '0;
                prs2_q[i]    <= '0;
            end
        end else if (do_enq) begin
            memwrite_q[tail_idx] <= i_disp_memwrite;
            alu_op_q[tail_idx]   <= i_disp_alu_op;
            imm_q[tail_idx]      <= i_disp_imm;
            prd_q[tail_idx]      <= i_disp_prd;
            rob_tag_q[tail_idx]  <= i_disp_rob_tag;
            prs1_q[tail_idx]     <= i_disp_prs1;
            prs2_q[tail_idx]     <= i_disp_prs2;
        end
    end

endmodule

// File: tb/tb_lsu_issue_queue.sv
// Testbench for lsu_issue_queue: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_lsu_issue_queue;

    localparam int DATA_WIDTH = 32;
    localparam int ROB_WIDTH  = 4;
    localparam int PREG_WIDTH = 7;
    localparam int DEPTH      = 8;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  i_flush;
    logic                  i_disp_valid;
    logic                  o_disp_ready;
    logic                  i_disp_memwrite;
    logic [3:0]            i_disp_alu_op;
    logic [DATA_WIDTH-1:0] i_disp_imm;
    logic [PREG_WIDTH-1:0] i_disp_prd;
    logic [ROB_WIDTH-1:0]  i_disp_rob_tag;
    logic [PREG_WIDTH-1:0] i_disp_prs1;
    logic [PREG_WIDTH-1:0] i_disp_prs2;
    logic                  i_disp_rs1_rdy;
    logic                  i_disp_rs2_rdy;
    logic [DATA_WIDTH-1:0] i_disp_rs1_val;
    logic [DATA_WIDTH-1:0] i_disp_rs2_val;
    logic                  i_cdb_valid;
    logic [PREG_WIDTH-1:0] i_cdb_prd;
    logic [DATA_WIDTH-1:0] i_cdb_data;
    logic                  o_issue_valid;
    logic                  i_lsu_ready;
    logic [DATA_WIDTH-1:0] o_base_addr;
    logic [DATA_WIDTH-1:0] o_offset;
    logic [DATA_WIDTH-1:0] o_store_data;
    logic                  o_memwrite;
    logic [3:0]            o_alu_op;
    logic [PREG_WIDTH-1:0] o_prd;
    logic [ROB_WIDTH-1:0]  o_rob_tag;
    logic [3:0]            o_count;
    logic                  o_empty;
    logic                  o_full;

    always #5 clk = ~clk;

    lsu_issue_queue #(
        .DATA_WIDTH(DATA_WIDTH), .ROB_WIDTH(ROB_WIDTH),
        .PREG_WIDTH(PREG_WIDTH), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .i_flush(i_flush),
        .i_disp_valid(i_disp_valid), .o_disp_ready(o_disp_ready),
        .i_disp_memwrite(i_disp_memwrite), .i_disp_alu_op(i_disp_alu_op),
        .i_disp_imm(i_disp_imm), .i_disp_prd(i_disp_prd), .i_disp_rob_tag(i_disp_rob_tag),
        .i_disp_prs1(i_disp_prs1), .i_disp_prs2(i_disp_prs2),
        .i_disp_rs1_rdy(i_disp_rs1_rdy), .i_disp_rs2_rdy(i_disp_rs2_rdy),
        .i_disp_rs1_val(i_disp_rs1_val), .i_disp_rs2_val(i_disp_rs2_val),
        .i_cdb_valid(i_cdb_valid), .i_cdb_prd(i_cdb_prd), .i_cdb_data(i_cdb_data),
        .o_issue_valid(o_issue_valid), .i_lsu_ready(i_lsu_ready),
        .o_base_addr(o_base_addr), .o_offset(o_offset), .o_store_data(o_store_data),
        .o_memwrite(o_memwrite), .o_alu_op(o_alu_op), .o_prd(o_prd), .o_rob_tag(o_rob_tag),
        .o_count(o_count), .o_empty(o_empty), .o_full(o_full)
    );

    // Reference model: the queue contents in program order.
    typedef struct {
        logic                  memwrite;
        logic [3:0]            alu_op;
        logic [DATA_WIDTH-1:0] imm;
        logic [PREG_WIDTH-1:0] prd;
        logic [ROB_WIDTH-1:0]  tag;
        logic [PREG_WIDTH-1:0] prs1;
        logic [PREG_WIDTH-1:0] prs2;
        logic                  r1;
        logic                  r2;
        logic [DATA_WIDTH-1:0] v1;
        logic [DATA_WIDTH-1:0] v2;
    } m_entry_t;

    m_entry_t mq[$];

    // Directed vector: inputs for one cycle and the outputs expected in that cycle.
    typedef struct {
        logic                  dv;
        logic                  mw;
        logic [PREG_WIDTH-1:0] prs1;
        logic                  r1;
        logic [DATA_WIDTH-1:0] v1;
        logic [PREG_WIDTH-1:0] prs2;
        logic                  r2;
        logic [DATA_WIDTH-1:0] v2;
        logic [DATA_WIDTH-1:0] imm;
        logic [PREG_WIDTH-1:0] prd;
        logic [ROB_WIDTH-1:0]  tag;
        logic                  cv;
        logic [PREG_WIDTH-1:0] cprd;
        logic [DATA_WIDTH-1:0] cdata;
        logic                  lr;
        logic                  e_iv;
        logic [3:0]            e_cnt;
        logic [DATA_WIDTH-1:0] e_base;
        logic [DATA_WIDTH-1:0] e_off;
        logic                  e_mw;
        logic [DATA_WIDTH-1:0] e_sd;
        logic [PREG_WIDTH-1:0] e_prd;
        logic [ROB_WIDTH-1:0]  e_tag;
    } vec_t;

    vec_t vecs[9];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_ready(input m_entry_t e);
        return e.r1 && (!e.memwrite || e.r2);
    endfunction

    function automatic bit m_issue();
        if (mq.size() == 0) return 1'b0;
        return m_ready(mq[0]) && !i_flush;
    endfunction

    // Compare every observable output against the model for the current cycle.
    task automatic model_check();
        bit exp_iv;
        exp_iv = m_issue();
        check("m_issue_valid", 64'(o_issue_valid), 64'(exp_iv));
        check("m_count", 64'(o_count), 64'(mq.size()));
        check("m_empty", 64'(o_empty), 64'(mq.size() == 0));
        check("m_full", 64'(o_full), 64'(mq.size() == DEPTH));
        check("m_disp_ready", 64'(o_disp_ready), 64'(mq.size() < DEPTH));
        if (exp_iv) begin
            check("m_base", 64'(o_base_addr), 64'(mq[0].v1));
            check("m_offset", 64'(o_offset), 64'(mq[0].imm));
            check("m_memwrite", 64'(o_memwrite), 64'(mq[0].memwrite));
            check("m_alu_op", 64'(o_alu_op), 64'(mq[0].alu_op));
            check("m_prd", 64'(o_prd), 64'(mq[0].prd));
            check("m_tag", 64'(o_rob_tag), 64'(mq[0].tag));
            if (mq[0].memwrite) check("m_store_data", 64'(o_store_data), 64'(mq[0].v2));
        end
    endtask

    // Apply the effect of the coming clock edge to the model.
    task automatic model_update();
        bit xfer;
        bit enq;
        m_entry_t e;
        if (i_flush) begin
            mq.delete();
            return;
        end
        xfer = m_issue() && i_lsu_ready;
        enq  = i_disp_valid && (mq.size() < DEPTH);
        if (i_cdb_valid) begin
            for (int k = 0; k < mq.size(); k++) begin
                e = mq[k];
                if (!e.r1 && e.prs1 == i_cdb_prd) begin e.r1 = 1'b1; e.v1 = i_cdb_data; end
                if (!e.r2 && e.prs2 == i_cdb_prd) begin e.r2 = 1'b1; e.v2 = i_cdb_data; end
                mq[k] = e;
            end
        end
        if (xfer) void'(mq.pop_front());
        if (enq) begin
            e.memwrite = i_disp_memwrite;
            e.alu_op   = i_disp_alu_op;
            e.imm      = i_disp_imm;
            e.prd      = i_disp_prd;
            e.tag      = i_disp_rob_tag;
            e.prs1     = i_disp_prs1;
            e.prs2     = i_disp_prs2;
            e.r1 = i_disp_rs1_rdy || (i_cdb_valid && i_disp_prs1 == i_cdb_prd);
            e.r2 = i_disp_rs2_rdy || (i_cdb_valid && i_disp_prs2 == i_cdb_prd);
            e.v1 = i_disp_rs1_rdy ? i_disp_rs1_val : (e.r1 ? i_cdb_data : i_disp_rs1_val);
            e.v2 = i_disp_rs2_rdy ? i_disp_rs2_val : (e.r2 ? i_cdb_data : i_disp_rs2_val);
            mq.push_back(e);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic lr);
        i_flush = 1'b0; i_disp_valid = 1'b0; i_disp_memwrite = 1'b0; i_disp_alu_op = '0;
        i_disp_imm = '0; i_disp_prd = '0; i_disp_rob_tag = '0; i_disp_prs1 = '0;
        i_disp_prs2 = '0; i_disp_rs1_rdy = 1'b0; i_disp_rs2_rdy = 1'b0;
        i_disp_rs1_val = '0; i_disp_rs2_val = '0; i_cdb_valid = 1'b0; i_cdb_prd = '0;
        i_cdb_data = '0; i_lsu_ready = lr;
    endtask

    // Dispatch a ready load with the given base, tag and destination.
    task automatic disp_load(input logic [DATA_WIDTH-1:0] base, input logic [ROB_WIDTH-1:0] tag,
                             input logic [PREG_WIDTH-1:0] prd, input logic lr);
        idle(lr);
        i_disp_valid = 1'b1; i_disp_rs1_rdy = 1'b1; i_disp_rs1_val = base;
        i_disp_imm = 32'h10; i_disp_rob_tag = tag; i_disp_prd = prd; i_disp_alu_op = 4'd2;
    endtask

    task automatic apply(input vec_t v);
        idle(v.lr);
        i_disp_valid = v.dv; i_disp_memwrite = v.mw; i_disp_prs1 = v.prs1; i_disp_rs1_rdy = v.r1;
        i_disp_rs1_val = v.v1; i_disp_prs2 = v.prs2; i_disp_rs2_rdy = v.r2; i_disp_rs2_val = v.v2;
        i_disp_imm = v.imm; i_disp_prd = v.prd; i_disp_rob_tag = v.tag; i_disp_alu_op = 4'd2;
        i_cdb_valid = v.cv; i_cdb_prd = v.cprd; i_cdb_data = v.cdata;
    endtask

    initial begin
        // Ready load, then a store waiting on p9 that blocks a younger ready load.
        vecs[0] = '{dv:1'b1, prs1:7'd1, r1:1'b1, v1:32'h100, imm:32'd4, prd:7'd5, tag:4'd3, lr:1'b1, default:'0};
        vecs[1] = '{lr:1'b1, e_iv:1'b1, e_cnt:4'd1, e_base:32'h100, e_off:32'd4, e_prd:7'd5, e_tag:4'd3, default:'0};
        vecs[2] = '{lr:1'b1, default:'0};
        vecs[3] = '{dv:1'b1, mw:1'b1, prs1:7'd1, r1:1'b1, v1:32'h200, prs2:7'd9, imm:32'd8, tag:4'd4, lr:1'b1, default:'0};
        vecs[4] = '{dv:1'b1, prs1:7'd2, r1:1'b1, v1:32'h300, prd:7'd6, tag:4'd5, lr:1'b1, e_cnt:4'd1, default:'0};
        vecs[5] = '{cv:1'b1, cprd:7'd9, cdata:32'hDEAD, lr:1'b1, e_cnt:4'd2, default:'0};
        vecs[6] = '{lr:1'b1, e_iv:1'b1, e_cnt:4'd2, e_base:32'h200, e_off:32'd8, e_mw:1'b1, e_sd:32'hDEAD, e_tag:4'd4, default:'0};
        vecs[7] = '{lr:1'b1, e_iv:1'b1, e_cnt:4'd1, e_base:32'h300, e_prd:7'd6, e_tag:4'd5, default:'0};
        vecs[8] = '{lr:1'b1, default:'0};

        // Power-up reset.
        idle(1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_issue_valid", 64'(o_issue_valid), 64'd0);
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_empty", 64'(o_empty), 64'd1);
        check("rst_full", 64'(o_full), 64'd0);
        check("rst_disp_ready", 64'(o_disp_ready), 64'd1);
        check("rst_base", 64'(o_base_addr), 64'd0);
        check("rst_tag", 64'(o_rob_tag), 64'd0);
        reset = 1'b0;
        mq.delete();

        // Directed table: ready load latency, head-of-line blocking, wakeup.
        for (int k = 0; k < 9; k++) begin
            apply(vecs[k]);
            settle();
            check($sformatf("tbl%0d_iv", k), 64'(o_issue_valid), 64'(vecs[k].e_iv));
            check($sformatf("tbl%0d_count", k), 64'(o_count), 64'(vecs[k].e_cnt));
            if (vecs[k].e_iv) begin
                check($sformatf("tbl%0d_base", k), 64'(o_base_addr), 64'(vecs[k].e_base));
                check($sformatf("tbl%0d_off", k), 64'(o_offset), 64'(vecs[k].e_off));
                check($sformatf("tbl%0d_prd", k), 64'(o_prd), 64'(vecs[k].e_prd));
                check($sformatf("tbl%0d_tag", k), 64'(o_rob_tag), 64'(vecs[k].e_tag));
                check($sformatf("tbl%0d_mw", k), 64'(o_memwrite), 64'(vecs[k].e_mw));
                if (vecs[k].e_mw) check($sformatf("tbl%0d_sd", k), 64'(o_store_data), 64'(vecs[k].e_sd));
            end
            advance();
        end

        // LSU stall: payload held, count unchanged, then exactly one transfer.
        disp_load(32'h400, 4'd1, 7'd7, 1'b0); settle(); advance();
        disp_load(32'h500, 4'd2, 7'd8, 1'b0); settle(); advance();
        idle(1'b0);
        for (int c = 0; c < 3; c++) begin
            settle();
            check("stall_iv", 64'(o_issue_valid), 64'd1);
            check("stall_base", 64'(o_base_addr), 64'h400);
            check("stall_tag", 64'(o_rob_tag), 64'd1);
            check("stall_count", 64'(o_count), 64'd2);
            advance();
        end
        idle(1'b1); settle(); advance();
        idle(1'b0); settle();
        check("stall_after_count", 64'(o_count), 64'd1);
        check("stall_after_tag", 64'(o_rob_tag), 64'd2);
        check("stall_after_base", 64'(o_base_addr), 64'h500);
        advance();
        idle(1'b1); settle(); advance();

        // Full queue: tail wraps, 9th dispatch dropped, full blocks dispatch even on pop.
        for (int i = 0; i < DEPTH; i++) begin
            disp_load(32'h1000 + 32'(i), 4'(i), 7'(i), 1'b0);
            settle(); advance();
        end
        disp_load(32'h2000, 4'd15, 7'd0, 1'b0); settle();
        check("full_flag", 64'(o_full), 64'd1);
        check("full_disp_ready", 64'(o_disp_ready), 64'd0);
        check("full_count", 64'(o_count), 64'd8);
        advance();
        disp_load(32'h2000, 4'd14, 7'd0, 1'b1); settle();
        check("full_pop_disp_ready", 64'(o_disp_ready), 64'd0);
        check("full_pop_tag", 64'(o_rob_tag), 64'd0);
        advance();
        idle(1'b1);
        for (int i = 1; i < DEPTH; i++) begin
            settle();
            check($sformatf("drain%0d_tag", i), 64'(o_rob_tag), 64'(i));
            check($sformatf("drain%0d_base", i), 64'(o_base_addr), 64'h1000 + 64'(i));
            advance();
        end
        settle();
        check("drain_empty", 64'(o_empty), 64'd1);
        advance();
        for (int i = 0; i < 5; i++) begin
            disp_load(32'h3000 + 32'(i), 4'(8 + i), 7'(i), 1'b0);
            settle(); advance();
        end
        idle(1'b1);
        for (int i = 0; i < 5; i++) begin
            settle();
            check($sformatf("wrap%0d_tag", i), 64'(o_rob_tag), 64'(8 + i));
            advance();
        end

        // Dispatch bypass from a same-cycle CDB broadcast.
        idle(1'b0);
        i_disp_valid = 1'b1; i_disp_prs1 = 7'd12; i_disp_rs1_val = 32'hBAD; i_disp_rob_tag = 4'd6;
        i_cdb_valid = 1'b1; i_cdb_prd = 7'd12; i_cdb_data = 32'h55;
        settle(); advance();
        idle(1'b0); settle();
        check("bypass_iv", 64'(o_issue_valid), 64'd1);
        check("bypass_base", 64'(o_base_addr), 64'h55);
        advance();
        idle(1'b1); settle(); advance();

        // Flush with three ready entries and a concurrent dispatch.
        for (int i = 0; i < 3; i++) begin
            disp_load(32'h600 + 32'(i), 4'(i + 1), 7'd3, 1'b0);
            settle(); advance();
        end
        disp_load(32'h700, 4'd9, 7'd3, 1'b1);
        i_flush = 1'b1;
        settle();
        check("flush_iv", 64'(o_issue_valid), 64'd0);
        advance();
        idle(1'b1); settle();
        check("flush_count", 64'(o_count), 64'd0);
        check("flush_empty", 64'(o_empty), 64'd1);
        advance();

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 3; i++) begin
            disp_load(32'h800 + 32'(i), 4'(i), 7'd4, 1'b0);
            settle(); advance();
        end
        disp_load(32'h900, 4'd7, 7'd4, 1'b1);
        reset = 1'b1;
        #1;
        check("arst_iv", 64'(o_issue_valid), 64'd0);
        check("arst_count", 64'(o_count), 64'd0);
        check("arst_empty", 64'(o_empty), 64'd1);
        check("arst_full", 64'(o_full), 64'd0);
        check("arst_disp_ready", 64'(o_disp_ready), 64'd1);
        mq.delete();
        idle(1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            i_flush         = ($urandom_range(0, 99) < 2);
            i_disp_valid    = ($urandom_range(0, 99) < 60);
            i_disp_memwrite = ($urandom_range(0, 1) == 1);
            i_disp_alu_op   = 4'($urandom_range(0, 15));
            i_disp_imm      = $urandom;
            i_disp_prd      = 7'($urandom_range(0, 7));
            i_disp_rob_tag  = 4'($urandom_range(0, 15));
            i_disp_prs1     = 7'($urandom_range(0, 7));
            i_disp_prs2     = 7'($urandom_range(0, 7));
            i_disp_rs1_rdy  = ($urandom_range(0, 1) == 1);
            i_disp_rs2_rdy  = ($urandom_range(0, 1) == 1);
            i_disp_rs1_val  = $urandom;
            i_disp_rs2_val  = $urandom;
            i_cdb_valid     = ($urandom_range(0, 99) < 40);
            i_cdb_prd       = 7'($urandom_range(0, 7));
            i_cdb_data      = $urandom;
            i_lsu_ready     = ($urandom_range(0, 99) < 70);
            settle();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
